serv_dbus_ram: RTL and testbench



---
 rtl/serv_dbus_ram.sv | 170 +++++++++++++++++
 tb/tb_serv_dbus_ram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_ram.sv
// Wishbone data-bus RAM for the SERV core: four byte-lane banks, WAIT wait states, one-cycle ack.
// Optional feature macro SERV_DBUS_ERR_EN: addresses >= DEPTH complete with o_wb_err instead of ack.

module serv_dbus_ram_lane #(
  parameter int IW     = 6,
  parameter int LANE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IW-1:0]     i_idx,
  input  logic [LANE_W-1:0] i_wdat,
  output logic [LANE_W-1:0] o_rdat
);

  logic [LANE_W-1:0] mem [0:(1<<IW)-1];
  logic [LANE_W-1:0] rdat_q, rdat_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_idx] <= i_wdat;
  end

  always_comb begin
    rdat_d = rdat_q;
    if (i_re) rdat_d = mem[i_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdat_q <= '0;
    else          rdat_q <= rdat_d;
  end

  assign o_rdat = rdat_q;

endmodule

module serv_dbus_ram #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int AW        = $clog2(DEPTH);
  localparam int IW        = AW - 2;
  localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } dbus_req_t;

  dbus_req_t req;
  assign req = '{adr: i_wb_adr, dat: i_wb_dat, sel: i_wb_sel, we: i_wb_we};

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       commit, commit_ok, do_xfer, oor;
  logic [IW-1:0] idx;

  logic [NUM_LANES-1:0][LANE_W-1:0] wdat, rdat;

  assign idx  = req.adr[AW-1:2];
  assign wdat = req.dat;

  // Word-aligned bits and (without the error feature) aliased high bits are don't-care.
  logic unused_adr;
  assign unused_adr = ^{req.adr[1:0], req.adr[31:AW]};

`ifdef SERV_DBUS_ERR_EN
  assign oor = |req.adr[31:AW];
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && !o_wb_ack) begin
          if (WAIT == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // An edge that lands while reset is held must never touch memory.
  assign commit_ok = commit & i_rst_n;
  assign do_xfer   = commit_ok & ~oor;
  assign ack_d     = do_xfer;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

`ifdef SERV_DBUS_ERR_EN
  logic err_q, err_d;
  assign err_d = commit_ok & oor;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign o_wb_err = err_q;
`else
  assign o_wb_err = 1'b0;
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    serv_dbus_ram_lane #(.IW(IW), .LANE_W(LANE_W)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (do_xfer & req.we & req.sel[l]),
      .i_re    (do_xfer & ~req.we),
      .i_idx   (idx),
      .i_wdat  (wdat[l]),
      .o_rdat  (rdat[l])
    );
  end

  assign o_wb_rdt = rdat;
  assign o_wb_ack = ack_q;

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Bench for serv_dbus_ram: three instances (WAIT = 0, 2, 3) each driven by random transactions and
// checked every cycle against a transaction-level memory model; a few literal pins anchor the model.

module tb_serv_dbus_ram;

  localparam int DEPTH = 256;
  localparam int NW    = DEPTH / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input int w, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL wait%0d %s: got %h expected %h at %0t", w, name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int W = (k == 0) ? 0 : ((k == 1) ? 2 : 3);

    logic        rst_n, cyc, we, ack, err;
    logic [31:0] adr, dat, rdt;
    logic [3:0]  sel;
    logic        exp_ack, exp_err;
    logic [31:0] exp_rdt;
    logic [31:0] mdl [NW];
    bit          chk_en = 1'b0;
    bit          done   = 1'b0;

    serv_dbus_ram #(.DEPTH(DEPTH), .WAIT(W)) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_wb_adr (adr),
      .i_wb_dat (dat),
      .i_wb_sel (sel),
      .i_wb_we  (we),
      .i_wb_cyc (cyc),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .o_wb_err (err)
    );

    always @(negedge clk) begin
      if (chk_en) begin
        check(W, "ack", 32'(ack), 32'(exp_ack));
        check(W, "err", 32'(err), 32'(exp_err));
        check(W, "rdt", rdt, exp_rdt);
      end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input logic hold);
      int  ix;
      logic is_err;
      adr = a; dat = d; sel = s; we = w; cyc = 1'b1;
      for (int c = 0; c <= W; c++) begin
        @(posedge clk); #1;
      end
      ix     = int'(a[7:2]);
      is_err = 1'b0;
`ifdef SERV_DBUS_ERR_EN
      is_err = |a[31:8];
`endif
      if (is_err) exp_err = 1'b1;
      else begin
        exp_ack = 1'b1;
        if (w) begin
          for (int l = 0; l < 4; l++)
            if (s[l]) mdl[ix][8*l +: 8] = d[8*l +: 8];
        end else exp_rdt = mdl[ix];
      end
      if (!hold) cyc = 1'b0;
      @(posedge clk); #1;
      exp_ack = 1'b0; exp_err = 1'b0; cyc = 1'b0;
    endtask

    task automatic abort_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w);
      int kk;
      kk  = $urandom_range(W, 1);
      adr = a; dat = d; sel = s; we = w; cyc = 1'b1;
      repeat (kk) begin
        @(posedge clk); #1;
      end
      cyc = 1'b0;
      @(posedge clk); #1;
    endtask

    task automatic reset_mid(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      adr = a; dat = d; sel = s; we = 1'b1; cyc = 1'b1;
      if (W > 0) begin
        @(posedge clk); #1;
      end
      #1;
      rst_n = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_rdt = '0;
      @(posedge clk); #1;
      cyc = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    endtask

    initial begin
      logic [31:0] a;
      int op;
      rst_n = 1'b1; cyc = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0;
      exp_ack = 1'b0; exp_err = 1'b0; exp_rdt = '0;
      chk_en = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NW; i++) txn(32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0);

      txn(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
      txn(32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
      check(W, "pin deadbeef", rdt, 32'hDEADBEEF);

      txn(32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0);
      txn(32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
      txn(32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
      check(W, "pin lanes", rdt, 32'h11BB33DD);

      txn(32'h24, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
      check(W, "pin write keeps rdt", rdt, 32'h11BB33DD);

      txn(32'h0, 32'h55AA55AA, 4'hF, 1'b1, 1'b0);
      txn(32'h100, 32'h12345678, 4'hF, 1'b1, 1'b0);
      txn(32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
`ifdef SERV_DBUS_ERR_EN
      check(W, "pin oor no write", rdt, 32'h55AA55AA);
`else
      check(W, "pin oor alias", rdt, 32'h12345678);
`endif

      if (W > 0) begin
        txn(32'h30, 32'h0BADF00D, 4'hF, 1'b1, 1'b0);
        abort_txn(32'h30, 32'hFFFFFFFF, 4'hF, 1'b1);
        txn(32'h30, 32'h0, 4'hF, 1'b0, 1'b0);
        check(W, "pin abort", rdt, 32'h0BADF00D);
      end

      txn(32'h34, 32'h600DCAFE, 4'hF, 1'b1, 1'b0);
      reset_mid(32'h34, 32'h0, 4'hF);
      check(W, "pin reset rdt", rdt, 32'h0);
      txn(32'h34, 32'h0, 4'hF, 1'b0, 1'b0);
      check(W, "pin after reset", rdt, 32'h600DCAFE);

      for (int n = 0; n < 150; n++) begin
        op = $urandom_range(0, 19);
        a  = 32'($urandom_range(0, NW - 1)) << 2;
        a[1:0] = 2'($urandom);
        if ($urandom_range(0, 4) == 0) a[31:8] = 24'($urandom);
        if (op < 14)
          txn(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
        else if (op < 19) begin
          if (W > 0) abort_txn(a, $urandom, 4'($urandom), 1'($urandom));
          else       txn(a, $urandom, 4'($urandom), 1'b0, 1'b0);
        end else
          reset_mid(a, $urandom, 4'($urandom));
      end

      for (int i = 0; i < NW; i++) txn(32'(i * 4), 32'h0, 4'($urandom), 1'b0, 1'b0);
      done = 1'b1;
    end
  end

  initial begin
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < 60000 && !fin; c++) begin
      @(posedge clk);
      fin = g_inst[0].done & g_inst[1].done & g_inst[2].done;
    end
    if (!fin) begin
      miscompares++;
      $display("FAIL timeout: got unfinished expected all instances done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
